// File: rtl/microcode_sequencer_if.sv
// Bus bundle for microcode_sequencer: control inputs, microcode loader port and status outputs.
interface microcode_sequencer_if #(
  parameter int OPCODE_W = 4,
  parameter int CTRL_W   = 15,
  parameter int T_STATES = 8
);
  localparam int SW = $clog2(T_STATES);

  logic [OPCODE_W-1:0]    opcode;
  logic                   run;
  logic                   uc_we;
  logic [OPCODE_W+SW:0]   uc_addr;
  logic [CTRL_W+1:0]      uc_wdata;
  logic                   step_mode;
  logic                   step;
  logic [CTRL_W-1:0]      ctrl_out;
  logic [SW-1:0]          stage_out;
  logic                   ready;
  logic                   halted;

  modport slave (
    input  opcode, run, uc_we, uc_addr, uc_wdata, step_mode, step,
    output ctrl_out, stage_out, ready, halted
  );

  modport master (
    output opcode, run, uc_we, uc_addr, uc_wdata, step_mode, step,
    input  ctrl_out, stage_out, ready, halted
  );
endinterface

// File: rtl/microcode_sequencer.sv
// Writable-table microcode sequencer: common fetch row plus one row per opcode, IDLE/RUN/HALT FSM.
// Optional single-step gating enabled by defining SINGLE_STEP_EN.
module microcode_sequencer #(
  parameter int                 OPCODE_W  = 4,
  parameter int                 CTRL_W    = 15,
  parameter int                 T_STATES  = 8,
  parameter int                 FETCH_LEN = 3,
  parameter logic [CTRL_W-1:0]  CTRL_IDLE = 15'b000111111100011
) (
  input  logic                  clk,
  input  logic                  resetn,
  microcode_sequencer_if.slave  bus
);
  localparam int SW   = $clog2(T_STATES);
  localparam int RW   = OPCODE_W + 1;
  localparam int ROWS = (1 << OPCODE_W) + 1;
  localparam logic [RW-1:0] FETCH_ROW = RW'(1 << OPCODE_W);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t              state_q, state_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [SW-1:0]       stage_q, stage_d;
  logic                ready_q, ready_d;

  logic [CTRL_W+1:0]   ucode_mem [ROWS][T_STATES];
  logic [RW-1:0]       wr_row, rd_row;
  logic [SW-1:0]       wr_stage;
  logic [CTRL_W+1:0]   w;
  logic                in_fetch, w_hlt, w_end, exec;

  // Table has no reset so a loaded program survives resetn.
  assign wr_row   = bus.uc_addr[OPCODE_W+SW] ? FETCH_ROW : {1'b0, bus.uc_addr[OPCODE_W+SW-1:SW]};
  assign wr_stage = bus.uc_addr[SW-1:0];

  always_ff @(posedge clk) begin
    if (bus.uc_we) ucode_mem[wr_row][wr_stage] <= bus.uc_wdata;
  end

  assign in_fetch = stage_q < SW'(FETCH_LEN);
  assign rd_row   = in_fetch ? FETCH_ROW : {1'b0, bus.opcode};
  assign w        = ucode_mem[rd_row][stage_q];
  // Sequencing flags in the fetch row are deliberately inert.
  assign w_hlt    = !in_fetch && w[CTRL_W+1];
  assign w_end    = !in_fetch && w[CTRL_W];

`ifdef SINGLE_STEP_EN
  assign exec = (state_q == RUN) && (!bus.step_mode || bus.step);
`else
  logic unused_step;
  assign exec        = (state_q == RUN);
  assign unused_step = bus.step_mode ^ bus.step;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      ctrl_q  <= CTRL_IDLE;
      stage_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      stage_q <= stage_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.run) state_d = RUN;
      RUN:     if (exec && w_hlt) state_d = HALT;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // HLT wins over END: stage freezes where the halting word was issued.
  always_comb begin
    ctrl_d  = CTRL_IDLE;
    ready_d = 1'b0;
    stage_d = stage_q;
    if (exec) begin
      ctrl_d  = w[CTRL_W-1:0];
      ready_d = (stage_q == '0);
      if (!w_hlt)
        stage_d = (w_end || stage_q == SW'(T_STATES-1)) ? '0 : stage_q + 1'b1;
    end
  end

  assign bus.ctrl_out  = ctrl_q;
  assign bus.stage_out = stage_q;
  assign bus.ready     = ready_q;
  assign bus.halted    = (state_q == HALT);
endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed bench for microcode_sequencer: fetch, END, wrap, HLT, async reset, table retention, stepping.
module tb_microcode_sequencer;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  localparam logic [14:0] IDLE_W = 15'b000111111100011;

  microcode_sequencer_if #(.OPCODE_W(4), .CTRL_W(15), .T_STATES(8)) bus ();

  microcode_sequencer dut (.clk(clk), .resetn(resetn), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [14:0] cw(input int r, input int s);
    logic [4:0] rr;
    logic [2:0] ss;
    rr = r[4:0];
    ss = s[2:0];
    return {rr, ss, 7'h55};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; issues one RUN edge and checks the registered result.
  task automatic exec_chk(input int s, input int op, input int nxt);
    int row;
    row = (s < 3) ? 16 : op;
    chk("stage_pre", 32'(bus.stage_out), 32'(s));
    @(posedge clk); @(negedge clk);
    chk("ctrl", 32'(bus.ctrl_out), 32'(cw(row, s)));
    chk("ready", 32'(bus.ready), 32'(s == 0));
    chk("stage_nxt", 32'(bus.stage_out), 32'(nxt));
  endtask

  task automatic chk_idle_out(input string tag);
    chk({tag, "_ctrl"}, 32'(bus.ctrl_out), 32'(IDLE_W));
    chk({tag, "_ready"}, 32'(bus.ready), 32'd0);
  endtask

  initial begin
    bus.opcode = '0; bus.run = 1'b0; bus.uc_we = 1'b0; bus.uc_addr = '0;
    bus.uc_wdata = '0; bus.step_mode = 1'b0; bus.step = 1'b0;

    // Load table under reset; fetch stage 1 carries HLT+END that must be ignored.
    for (int r = 0; r <= 16; r++) begin
      for (int s = 0; s < 8; s++) begin
        logic hlt, en;
        hlt = 1'b0; en = 1'b0;
        if (r == 16 && s == 1) begin hlt = 1'b1; en = 1'b1; end
        if (r == 2 && s == 5) en = 1'b1;
        if (r == 0 && s == 3) begin hlt = 1'b1; en = 1'b1; end
        @(negedge clk);
        bus.uc_we    = 1'b1;
        bus.uc_addr  = (r == 16) ? {1'b1, 4'h0, 3'(s)} : {1'b0, 4'(r), 3'(s)};
        bus.uc_wdata = {hlt, en, cw(r, s)};
      end
    end
    @(negedge clk);
    bus.uc_we = 1'b0;

    chk_idle_out("rst");
    chk("rst_stage", 32'(bus.stage_out), 32'd0);
    chk("rst_halted", 32'(bus.halted), 32'd0);

    resetn = 1'b1;
    @(posedge clk); @(negedge clk);
    chk_idle_out("idle_norun");

    // op 2: fetch 0..2, row stages 3..5 with END at 5, straight into next fetch
    bus.run = 1'b1; bus.opcode = 4'd2;
    @(posedge clk); @(negedge clk);
    chk_idle_out("enter_run");
    bus.run = 1'b0;
    for (int s = 0; s < 6; s++) exec_chk(s, 2, (s == 5) ? 0 : s + 1);
    chk("fetch_hlt_ignored", 32'(bus.halted), 32'd0);
    exec_chk(0, 2, 1);
    exec_chk(1, 2, 2);

    // op 7: no END, runs to last stage and wraps
    bus.opcode = 4'd7;
    for (int s = 2; s < 8; s++) exec_chk(s, 7, (s + 1) % 8);
    for (int s = 0; s < 4; s++) exec_chk(s, 7, s + 1);

    // async reset at stage 4, between edges
    #2 resetn = 1'b0;
    #1;
    chk_idle_out("async_rst");
    chk("async_rst_stage", 32'(bus.stage_out), 32'd0);
    chk("async_rst_halted", 32'(bus.halted), 32'd0);
    @(negedge clk);
    resetn = 1'b1; bus.run = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.run = 1'b0;

    // rerun op 7 after reset; same-edge rewrite of row7/stage7 must read the old word
    for (int s = 0; s < 8; s++) begin
      if (s == 7) begin
        bus.uc_we = 1'b1; bus.uc_addr = {1'b0, 4'd7, 3'd7}; bus.uc_wdata = {2'b00, 15'h7FFF};
      end
      exec_chk(s, 7, (s + 1) % 8);
      bus.uc_we = 1'b0;
    end

    // op 0: HLT+END together at stage 3
    bus.opcode = 4'd0;
    for (int s = 0; s < 3; s++) exec_chk(s, 0, s + 1);
    exec_chk(3, 0, 3);
    chk("halt_flag", 32'(bus.halted), 32'd1);
    for (int k = 0; k < 4; k++) begin
      bus.run = k[0];
      @(posedge clk); @(negedge clk);
      chk_idle_out("halted_hold");
      chk("halted_stage", 32'(bus.stage_out), 32'd3);
      chk("halted_stay", 32'(bus.halted), 32'd1);
    end
    bus.run = 1'b0;

    #2 resetn = 1'b0;
    #1;
    chk("halt_rst_halted", 32'(bus.halted), 32'd0);
    chk("halt_rst_stage", 32'(bus.stage_out), 32'd0);
    @(negedge clk);
    resetn = 1'b1; bus.run = 1'b1; bus.opcode = 4'd2;
    @(posedge clk); @(negedge clk);
    bus.run = 1'b0;
    bus.step_mode = 1'b1;

`ifdef SINGLE_STEP_EN
    begin
      int s;
      s = 0;
      for (int k = 0; k < 9; k++) begin
        bus.step = (k % 3 == 2);
        if (bus.step) begin
          exec_chk(s, 2, s + 1);
          s++;
        end else begin
          @(posedge clk); @(negedge clk);
          chk_idle_out("step_gap");
          chk("step_hold", 32'(bus.stage_out), 32'(s));
        end
      end
      bus.step = 1'b0;
    end
`else
    bus.step = 1'b0;
    exec_chk(0, 2, 1);
    exec_chk(1, 2, 2);
    exec_chk(2, 2, 3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/microcode_sequencer.md
MICROCODE_SEQUENCER -- requirements
Module: microcode_sequencer

Interface
REQ-001 Parameters (name, default, meaning), one per line, as REQ-002..REQ-006.
REQ-002 The block SHALL have parameter OPCODE_W, 4, opcode width.
REQ-003 The block SHALL have parameter CTRL_W, 15, control word width.
REQ-004 The block SHALL have parameter T_STATES, 8, micro-stages per instruction; power of two, >= FETCH_LEN+1.
REQ-005 The block SHALL have parameter FETCH_LEN, 3, common fetch stages.
REQ-006 The block SHALL have parameter CTRL_IDLE, 15'b000111111100011, all-deasserted control word (active-low bits high).
REQ-007 Ports (name direction width meaning), one per line, as REQ-008..REQ-020; one clock; reset asynchronous, active-low.
REQ-008 The block SHALL have port clk, input, 1, sole clock, rising edge.
REQ-009 The block SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-010 The block SHALL have port opcode, input, OPCODE_W, live opcode from instruction register.
REQ-011 The block SHALL have port run, input, 1, start request.
REQ-012 The block SHALL have port uc_we, input, 1, microcode write strobe.
REQ-013 The block SHALL have port uc_addr, input, OPCODE_W+1+log2(T_STATES), {row,stage}; row MSB=1 selects the fetch row.
REQ-014 The block SHALL have port uc_wdata, input, CTRL_W+2, {HLT,END,ctrl}.
REQ-015 The block SHALL have port step_mode, input, 1, single-step enable.
REQ-016 The block SHALL have port step, input, 1, advance one micro-stage.
REQ-017 The block SHALL have port ctrl_out, output, CTRL_W, registered control word.
REQ-018 The block SHALL have port stage_out, output, log2(T_STATES), current stage.
REQ-019 The block SHALL have port ready, output, 1, high the cycle after stage 0 issues.
REQ-020 The block SHALL have port halted, output, 1, HALT state.

Function
REQ-021 The FSM SHALL have states IDLE, RUN and HALT; IDLE->RUN on the first edge with run=1; RUN->HALT per REQ-025; HALT exits only via reset.
REQ-022 The microcode table SHALL be 2^OPCODE_W opcode rows plus one fetch row, T_STATES words each; writes with uc_we=1 SHALL take effect at the edge and be allowed in any state; a same-edge read of the written entry SHALL return the old word.
REQ-023 On each RUN edge the block SHALL read word w from the fetch row if stage<FETCH_LEN, else from row opcode; ctrl_out<=w.ctrl; ready<=(stage==0); latency one cycle from stage to ctrl_out.
REQ-024 Stage SHALL advance to 0 if w.END=1 or stage==T_STATES-1, else stage+1; END/HLT in fetch-row words SHALL be ignored.
REQ-025 If w.HLT=1 (opcode row) the block SHALL output w.ctrl for that one cycle, enter HALT, then hold ctrl_out=CTRL_IDLE, halted=1, stage frozen.
REQ-026 In IDLE and HALT, ctrl_out SHALL be CTRL_IDLE and ready 0; run SHALL be ignored in HALT.
REQ-027 The block SHALL let HLT and END set together, with HLT taking precedence.

Reset
REQ-028 resetn=0 SHALL asynchronously force state=IDLE, stage=0, ctrl_out=CTRL_IDLE, ready=0, halted=0, including mid-instruction and in HALT.
REQ-029 Reset SHALL NOT clear microcode contents; the bench/loader SHALL write the table before asserting run.

Configuration
REQ-030 With SINGLE_STEP_EN defined and step_mode=1, a RUN edge SHALL execute REQ-023..REQ-025 only when step=1; otherwise stage SHALL hold, ctrl_out=CTRL_IDLE, ready=0.
REQ-031 Without SINGLE_STEP_EN, step_mode and step SHALL be ignored (ports retained, unused).

Verification
REQ-032 The bench SHALL cover: reset, then run=1 with fetch row loaded -> stages 0,1,2 emit fetch words 1 cycle later; ready=1 only for stage 0.
REQ-033 The bench SHALL cover: opcode 2 row, END at stage 5 -> stage sequence 0..5,0; ctrl_out matches row words; no IDLE gap.
REQ-034 The bench SHALL cover: opcode 0 stage 3 word HLT=1 -> that ctrl word for 1 cycle, then halted=1, ctrl_out=15'b000111111100011; run toggling has no effect.
REQ-035 The bench SHALL cover: opcode 7 with no END bits -> stages 0..7 then wrap to 0.
REQ-036 The bench SHALL cover: resetn low at stage 4, mid-clock -> outputs reset immediately, without waiting for an edge; microcode survives (rerun gives identical trace).
REQ-037 The bench SHALL cover: SINGLE_STEP_EN, step_mode=1, step pulsed every 3rd cycle -> one stage per pulse, CTRL_IDLE between pulses.
